// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor.
// Takes WIDTH cycles per operation and processes one bit per cycle, LSB first.
// The datapath is a single full-adder/full-subtractor cell plus one carry/borrow flop.
// Optional signed-overflow output: define SERIAL_ADDSUB_OVF_EN to add the ovf port and its logic.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single bit cell: the operand bits are selected by the counter.
  // The result is assembled by shifting in from the MSB, so after WIDTH cycles bit 0 sits at the LSB.
  logic abit, bbit, sbit, cnext, last;
  assign abit  = a_q[cnt_q];
  assign bbit  = b_q[cnt_q];
  assign sbit  = abit ^ bbit ^ c_q;
  assign cnext = mode_q ? ((~abit & bbit) | (c_q & ~(abit ^ bbit)))
                        : ((abit & bbit) | (c_q & (abit ^ bbit)));
  assign last  = (cnt_q == CW'(WIDTH - 1));

  // Next-state logic: accept start in IDLE/DONE, step one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    c_d     = c_q;
    res_d   = res_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          c_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d = {sbit, res_q[WIDTH-1:1]};
        c_d   = cnext;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
          // sbit is the result MSB on the final step.
          ovf_d = mode_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (sbit != a_q[WIDTH-1]))
                         : ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (sbit != a_q[WIDTH-1]));
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      res_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      res_q   <= res_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign result = res_q;
  assign cb     = c_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..64.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port start  input  1  request to begin an operation.
REQ-005 SHALL provide port mode  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-006 SHALL provide port a  input  WIDTH  first operand.
REQ-007 SHALL provide port b  input  WIDTH  second operand.
REQ-008 SHALL provide port result  output  WIDTH  sum or difference, LSB-first assembled.
REQ-009 SHALL provide port cb  output  1  carry-out (add) or borrow-out (sub).
REQ-010 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-011 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-012 SHALL provide port ovf  output  1  signed overflow flag, present only when SERIAL_ADDSUB_OVF_EN is defined.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; IDLE after reset.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance, capture a, b and mode, clear the bit counter, and preset the carry/borrow flop to 0; go to RUN.
REQ-015 SHALL ignore start, a, b and mode while in RUN; captured values are not disturbed.
REQ-016 SHALL process one bit per cycle in RUN, LSB first, using one full-adder/full-subtractor cell and one carry/borrow flop.
REQ-017 SHALL compute add bit: s = a^b^c, c' = ab | c(a^b); subtract bit: d = a^b^br, br' = (~a)b | br(~(a^b)).
REQ-018 SHALL stay in RUN exactly WIDTH cycles, then go to DONE; start accepted at edge N gives done high during the cycle after edge N+WIDTH.
REQ-019 SHALL hold busy high from the edge accepting start until the edge entering DONE; low otherwise.
REQ-020 SHALL assert done only in DONE, for exactly one cycle; DONE goes to IDLE unless start is high, in which case it goes directly to RUN (back-to-back, no bubble).
REQ-021 SHALL hold result and cb stable from entering DONE until the next accepted start; both change only during RUN.
REQ-022 SHALL give cb = 1 for add when the unsigned sum exceeds 2^WIDTH-1, and for subtract when a < b unsigned.
REQ-023 SHALL wrap result modulo 2^WIDTH.

Reset
REQ-024 SHALL on rst_n low, immediately and regardless of clk: FSM to IDLE, result = 0, cb = 0, busy = 0, done = 0, ovf = 0, counter = 0, captured operands = 0.
REQ-025 SHALL abandon any in-progress operation on reset; no done pulse is produced for it.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro SERIAL_ADDSUB_OVF_EN is defined, provide ovf, updated when entering DONE: add: sign(a)==sign(b) and sign(result)!=sign(a); subtract: sign(a)!=sign(b) and sign(result)!=sign(a); held like result.
REQ-028 SHALL, when SERIAL_ADDSUB_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour is unchanged.

Verification (WIDTH=8)
REQ-029 SHALL cover: add 0x7F+0x01 -> result 0x80, cb 0, ovf 1, done 8 cycles after the start edge plus one.
REQ-030 SHALL cover: add 0xFF+0x01 -> result 0x00, cb 1, ovf 0.
REQ-031 SHALL cover: subtract 0x05-0x07 -> result 0xFE, cb 1, ovf 0; subtract 0x80-0x01 -> 0x7F, cb 0, ovf 1.
REQ-032 SHALL cover: start pulsed with new operands in RUN cycle 3 -> ignored, original result delivered, single done pulse.
REQ-033 SHALL cover: start held high in DONE -> next operation begins with no idle cycle, done pulses 9 cycles apart.
REQ-034 SHALL cover: rst_n low during RUN cycle 4 -> all outputs 0 immediately, no done pulse, a new start after release completes correctly.
